// File: rtl/load_store_unit.sv
// Load/store stage: turns a load or store from the single-cycle datapath into a
// request/grant/response bus transaction, holding stall until it retires.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    output logic        stall,
    output logic [31:0] loadData,
    output logic        misaligned,
    output logic        busError,
    output logic        busReq,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [3:0]  busBe,
    output logic [31:0] busWdata,
    input  logic        busGnt,
    input  logic        busRvalid,
    input  logic [31:0] busRdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [3:0]       bus_be_q, bus_be_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       off_q, off_d;
    logic [31:0]      load_data_q, load_data_d;
    logic             bus_error_q, bus_error_d;

    logic        req_any;
    logic        is_load;
    logic        legal_f3;
    logic        aligned;
    logic        access_ok;
    logic        idle_req;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] rdata_shift;
    logic [31:0] rdata_ext;

    // ---------------------------------------------------------------
    // Request decode (only meaningful in IDLE)
    // ---------------------------------------------------------------
    always_comb begin
        req_any = memRead | memWrite;
        is_load = memRead;
        if (is_load) begin
            legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b101);
        end else begin
            legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end
        case (funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        access_ok = legal_f3 & aligned;
        idle_req  = (state_q == S_IDLE) & req_any;
    end

    always_comb begin
        case (funct3[1:0])
            2'b00:   be_new = 4'b0001 << addr[1:0];
            2'b01:   be_new = 4'b0011 << addr[1:0];
            default: be_new = 4'b1111;
        endcase
    end

    // Write data replicated so each lane carries the byte it would own
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
            always_comb begin
                case (funct3[1:0])
                    2'b00:   wdata_new[8*gi +: 8] = storeData[7:0];
                    2'b01:   wdata_new[8*gi +: 8] = storeData[8*(gi % 2) +: 8];
                    default: wdata_new[8*gi +: 8] = storeData[8*gi +: 8];
                endcase
            end
        end
    endgenerate

    // ---------------------------------------------------------------
    // Read lane select and extension
    // ---------------------------------------------------------------
    always_comb begin
        rdata_shift = busRdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  rdata_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  rdata_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b100:  rdata_ext = {24'd0, rdata_shift[7:0]};
            3'b101:  rdata_ext = {16'd0, rdata_shift[15:0]};
            default: rdata_ext = rdata_shift;
        endcase
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        load_data_d = load_data_q;
        bus_error_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_any && access_ok) begin
                    state_d     = S_REQ;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = ~is_load;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_be_d    = be_new;
                    bus_wdata_d = wdata_new;
                    funct3_d    = funct3;
                    off_d       = addr[1:0];
                end
            end
            S_REQ, S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Timeout wins over a same-cycle grant/response so no access
                // ever spends more than TIMEOUT_CYCLES in REQ+WAIT.
                if (cnt_q == CNT_LAST) begin
                    state_d     = S_DONE;
                    bus_req_d   = 1'b0;
                    bus_error_d = 1'b1;
                    load_data_d = '0;
                end else if (state_q == S_REQ) begin
                    if (busGnt) begin
                        bus_req_d = 1'b0;
                        state_d   = bus_we_q ? S_DONE : S_WAIT;
                    end
                end else if (busRvalid) begin
                    load_data_d = rdata_ext;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            load_data_q <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            load_data_q <= load_data_d;
            bus_error_q <= bus_error_d;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    always_comb begin
        misaligned = reset & idle_req & ~access_ok;
        stall      = reset & ((idle_req & access_ok) |
                              (state_q == S_REQ) | (state_q == S_WAIT));
        loadData   = misaligned ? 32'd0 : load_data_q;
        busError   = bus_error_q;
        busReq     = bus_req_q;
        busWe      = bus_we_q;
        busAddr    = bus_addr_q;
        busBe      = bus_be_q;
        busWdata   = bus_wdata_q;
    end

endmodule
